// File: rtl/ctrl_unit_intr_if.sv
// Control-unit interface: instruction/status inputs, strobe and state outputs.
// master = control unit (drives strobes), slave = datapath/memory side.
interface ctrl_unit_intr_if #(
    parameter int WORD_W = 16,
    parameter int SC_W   = 3
);
    logic [WORD_W-1:0] ir;
    logic              ac_zero;
    logic              ac_neg;
    logic              dr_zero;
    logic              e_flag;
    logic              fgi;
    logic              fgo;
    logic              mem_ready;
    logic              run;
    logic [5:0]        ld;
    logic [5:0]        inr;
    logic [5:0]        clr;
    logic              mem_rd;
    logic              mem_wr;
    logic [2:0]        bus_sel;
    logic [2:0]        alu_op;
    logic [SC_W-1:0]   sc;
    logic              r_cycle;
    logic              ien;
    logic              halted;

    modport master (
        input  ir, ac_zero, ac_neg, dr_zero, e_flag, fgi, fgo,
        input  mem_ready, run,
        output ld, inr, clr, mem_rd, mem_wr, bus_sel, alu_op,
        output sc, r_cycle, ien, halted
    );

    modport slave (
        output ir, ac_zero, ac_neg, dr_zero, e_flag, fgi, fgo,
        output mem_ready, run,
        input  ld, inr, clr, mem_rd, mem_wr, bus_sel, alu_op,
        input  sc, r_cycle, ien, halted
    );
endinterface

// File: rtl/ctrl_unit_intr.sv
// Hardwired basic-computer control unit with interrupt cycle, wait states, halt.
// Ports: clk, reset (async, active-low), bus (ctrl_unit_intr_if.master).
module ctrl_unit_intr #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 12,
    parameter int SC_W   = 3
) (
    input logic              clk,
    input logic              reset,
    ctrl_unit_intr_if.master bus
);
    // strobe vector bit positions: {AR,PC,DR,AC,IR,TR}
    localparam int S_AR = 5;
    localparam int S_PC = 4;
    localparam int S_DR = 3;
    localparam int S_AC = 2;
    localparam int S_IR = 1;
    localparam int S_TR = 0;

    localparam logic [2:0] BS_AR  = 3'd1;
    localparam logic [2:0] BS_PC  = 3'd2;
    localparam logic [2:0] BS_DR  = 3'd3;
    localparam logic [2:0] BS_AC  = 3'd4;
    localparam logic [2:0] BS_IR  = 3'd5;
    localparam logic [2:0] BS_TR  = 3'd6;
    localparam logic [2:0] BS_MEM = 3'd7;

    localparam logic [2:0] ALU_INPR = 3'd4;
    localparam logic [2:0] ALU_CMA  = 3'd5;
    localparam logic [2:0] ALU_CIR  = 3'd6;
    localparam logic [2:0] ALU_CIL  = 3'd7;

    logic [SC_W-1:0]   sc_q;
    logic              r_q;
    logic              ien_q;
    logic              halted_q;

    logic              i_bit;
    logic [2:0]        op;
    logic [ADDR_W-1:0] addr_f;
    logic [11:0]       b;
    logic              int_cyc;
    logic              t4;

    logic [5:0]        ld_c;
    logic [5:0]        inr_c;
    logic [5:0]        clr_c;
    logic              rd_c;
    logic              wr_c;
    logic [2:0]        bsel_c;
    logic [2:0]        aop_c;
    logic              fin;
    logic              ion;
    logic              iof;
    logic              hlt;
    logic              rt_end;
    logic              stall;
    logic              quiet;
    logic              hold;
    logic              set_r;

    assign i_bit  = bus.ir[WORD_W-1];
    assign op     = bus.ir[WORD_W-2:WORD_W-4];
    assign addr_f = bus.ir[ADDR_W-1:0];
    assign b      = addr_f[11:0];
    assign t4     = (sc_q == SC_W'(4));

    // instruction decode is suppressed only for the fetch slots of an
    // interrupt; an R set mid-instruction lets the instruction finish
    assign int_cyc = r_q && (sc_q < SC_W'(3));

    always_comb begin
        ld_c   = '0;
        inr_c  = '0;
        clr_c  = '0;
        rd_c   = 1'b0;
        wr_c   = 1'b0;
        bsel_c = 3'd0;
        aop_c  = 3'd0;
        fin    = 1'b0;
        ion    = 1'b0;
        iof    = 1'b0;
        hlt    = 1'b0;
        rt_end = 1'b0;
        if (int_cyc) begin
            case (sc_q)
                SC_W'(0): begin
                    clr_c[S_AR] = 1'b1;
                    ld_c[S_TR]  = 1'b1;
                    bsel_c      = BS_PC;
                end
                SC_W'(1): begin
                    wr_c        = 1'b1;
                    bsel_c      = BS_TR;
                    clr_c[S_PC] = 1'b1;
                end
                default: begin
                    inr_c[S_PC] = 1'b1;
                    fin         = 1'b1;
                    rt_end      = 1'b1;
                end
            endcase
        end else begin
            case (sc_q)
                SC_W'(0): begin
                    ld_c[S_AR] = 1'b1;
                    bsel_c     = BS_PC;
                end
                SC_W'(1): begin
                    rd_c        = 1'b1;
                    bsel_c      = BS_MEM;
                    ld_c[S_IR]  = 1'b1;
                    inr_c[S_PC] = 1'b1;
                end
                SC_W'(2): begin
                    ld_c[S_AR] = 1'b1;
                    bsel_c     = BS_IR;
                end
                SC_W'(3): begin
                    if (op == 3'd7) begin
                        fin = 1'b1;
                        if (!i_bit) begin
                            if (b[11]) clr_c[S_AC] = 1'b1;
                            if (b[9]) begin
                                ld_c[S_AC] = 1'b1;
                                aop_c      = ALU_CMA;
                            end
                            if (b[7]) begin
                                ld_c[S_AC] = 1'b1;
                                aop_c      = ALU_CIR;
                            end
                            if (b[6]) begin
                                ld_c[S_AC] = 1'b1;
                                aop_c      = ALU_CIL;
                            end
                            if (b[5]) inr_c[S_AC] = 1'b1;
                            if ((b[4] && !bus.ac_neg) ||
                                (b[3] && bus.ac_neg) ||
                                (b[2] && bus.ac_zero) ||
                                (b[1] && !bus.e_flag))
                                inr_c[S_PC] = 1'b1;
                            hlt = b[0];
                        end else begin
                            if (b[11]) begin
                                ld_c[S_AC] = 1'b1;
                                aop_c      = ALU_INPR;
                            end
                            if (b[10]) bsel_c = BS_AC;
                            if ((b[9] && bus.fgi) || (b[8] && bus.fgo))
                                inr_c[S_PC] = 1'b1;
                            ion = b[7];
                            iof = b[6];
                        end
                    end else if (i_bit) begin
                        rd_c       = 1'b1;
                        bsel_c     = BS_MEM;
                        ld_c[S_AR] = 1'b1;
                    end
                end
                default: begin
                    fin = 1'b1;
                    case (op)
                        3'd0, 3'd1, 3'd2: begin
                            if (t4) begin
                                rd_c       = 1'b1;
                                bsel_c     = BS_MEM;
                                ld_c[S_DR] = 1'b1;
                                fin        = 1'b0;
                            end else begin
                                ld_c[S_AC] = 1'b1;
                                aop_c      = op + 3'd1;
                            end
                        end
                        3'd3: begin
                            wr_c   = 1'b1;
                            bsel_c = BS_AC;
                        end
                        3'd4: begin
                            ld_c[S_PC] = 1'b1;
                            bsel_c     = BS_AR;
                        end
                        3'd5: begin
                            if (t4) begin
                                wr_c        = 1'b1;
                                bsel_c      = BS_PC;
                                inr_c[S_AR] = 1'b1;
                                fin         = 1'b0;
                            end else begin
                                ld_c[S_PC] = 1'b1;
                                bsel_c     = BS_AR;
                            end
                        end
                        3'd6: begin
                            if (t4) begin
                                rd_c       = 1'b1;
                                bsel_c     = BS_MEM;
                                ld_c[S_DR] = 1'b1;
                                fin        = 1'b0;
                            end else if (sc_q == SC_W'(5)) begin
                                inr_c[S_DR] = 1'b1;
                                fin         = 1'b0;
                            end else begin
                                wr_c        = 1'b1;
                                bsel_c      = BS_DR;
                                inr_c[S_PC] = bus.dr_zero;
                            end
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    assign stall = (rd_c | wr_c) & ~bus.mem_ready;
    assign quiet = halted_q | ~reset;
    assign hold  = quiet | stall;
    assign set_r = (sc_q >= SC_W'(3)) & ien_q & (bus.fgi | bus.fgo);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sc_q     <= '0;
            r_q      <= 1'b0;
            ien_q    <= 1'b0;
            halted_q <= 1'b0;
        end else if (halted_q) begin
            if (bus.run) halted_q <= 1'b0;
        end else if (!stall) begin
            sc_q <= fin ? '0 : sc_q + SC_W'(1);
            if (set_r) r_q <= 1'b1;
            else if (rt_end) r_q <= 1'b0;
            // ION uses the old IEN for set_r above, so no same-edge R
            if (ion) ien_q <= 1'b1;
            else if (iof | rt_end) ien_q <= 1'b0;
            if (hlt) halted_q <= 1'b1;
        end
    end

    assign bus.ld      = hold ? '0 : ld_c;
    assign bus.inr     = hold ? '0 : inr_c;
    assign bus.clr     = hold ? '0 : clr_c;
    assign bus.mem_rd  = quiet ? 1'b0 : rd_c;
    assign bus.mem_wr  = quiet ? 1'b0 : wr_c;
    assign bus.bus_sel = quiet ? 3'd0 : bsel_c;
    assign bus.alu_op  = quiet ? 3'd0 : aop_c;
    assign bus.sc      = sc_q;
    assign bus.r_cycle = r_q;
    assign bus.ien     = ien_q;
    assign bus.halted  = halted_q;
endmodule

// File: tb/tb_ctrl_unit_intr.sv
// Bench for ctrl_unit_intr: per-instruction micro-op lists vs DUT outputs.
// Drives the interface slave side; directed cases then random instructions.
module tb_ctrl_unit_intr;
    localparam logic [5:0] AR = 6'b100000;
    localparam logic [5:0] PC = 6'b010000;
    localparam logic [5:0] DR = 6'b001000;
    localparam logic [5:0] AC = 6'b000100;
    localparam logic [5:0] IR = 6'b000010;
    localparam logic [5:0] TR = 6'b000001;
    localparam logic [5:0] Z  = 6'b000000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ctrl_unit_intr_if bus_if ();

    ctrl_unit_intr dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int          checks = 0;
    int          fails  = 0;
    logic        m_r;
    logic        m_ien;
    logic [15:0] cur_ir;
    logic [5:0]  cur_fl;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [25:0] mk(logic [5:0] l, logic [5:0] i,
                                       logic [5:0] c, int rd, int wr,
                                       int bs, int ao);
        return {l, i, c, 1'(rd), 1'(wr), 3'(bs), 3'(ao)};
    endfunction

    function automatic logic [25:0] obs();
        return {bus_if.ld, bus_if.inr, bus_if.clr, bus_if.mem_rd,
                bus_if.mem_wr, bus_if.bus_sel, bus_if.alu_op};
    endfunction

    // One timing slot k: nst wait cycles (memory slots only), then the
    // completing cycle. Strobes must be silent while waiting.
    task automatic step(input int k, input logic [25:0] sig,
                        input int nst, inout int nc);
        logic  mem;
        int    n;
        string tg;
        mem = sig[7] | sig[6];
        n   = mem ? nst : 0;
        for (int s = 0; s <= n; s++) begin
            @(negedge clk);
            bus_if.ir = cur_ir;
            {bus_if.ac_zero, bus_if.ac_neg, bus_if.dr_zero,
             bus_if.e_flag, bus_if.fgi, bus_if.fgo} = cur_fl;
            bus_if.run = 1'b0;
            bus_if.mem_ready = mem ? (s == n) : 1'($urandom_range(0, 1));
            #1;
            tg = (s < n) ? "stall_sig" : "sig";
            chk("sc", 32'(bus_if.sc), 32'(k));
            chk("r_cycle", 32'(bus_if.r_cycle), 32'(m_r));
            chk("ien", 32'(bus_if.ien), 32'(m_ien));
            chk("halted", 32'(bus_if.halted), 32'd0);
            chk(tg, 32'(obs()), 32'((s < n) ? (sig & 26'h00000ff) : sig));
            nc++;
        end
    endtask

    function automatic int pick(input int st_idx, input int st_n, input int k);
        if (st_idx >= 0) return (k == st_idx) ? st_n : 0;
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    task automatic run_instr(input logic [15:0] irv, input logic [5:0] fl,
                             input int st_idx, input int st_n,
                             output int nc);
        logic [25:0] q[$];
        logic [2:0]  op;
        logic        iv;
        logic [11:0] b;
        logic        az, an, dz, ef, fi, fo;
        logic [5:0]  l, i, c;
        int          bs, ao;
        logic        ion, iof, hlt;
        cur_ir = irv;
        cur_fl = fl;
        {az, an, dz, ef, fi, fo} = fl;
        iv  = irv[15];
        op  = irv[14:12];
        b   = irv[11:0];
        nc  = 0;
        ion = 1'b0;
        iof = 1'b0;
        hlt = 1'b0;
        q.push_back(mk(AR, Z, Z, 0, 0, 2, 0));
        q.push_back(mk(IR, PC, Z, 1, 0, 7, 0));
        q.push_back(mk(AR, Z, Z, 0, 0, 5, 0));
        if (op == 3'd7) begin
            l = Z; i = Z; c = Z; bs = 0; ao = 0;
            if (!iv) begin
                if (b[11]) c = AC;
                if (b[9]) begin l = AC; ao = 5; end
                if (b[7]) begin l = AC; ao = 6; end
                if (b[6]) begin l = AC; ao = 7; end
                if (b[5]) i = AC;
                if (b[4] && !an) i = PC;
                if (b[3] && an) i = PC;
                if (b[2] && az) i = PC;
                if (b[1] && !ef) i = PC;
                hlt = b[0];
            end else begin
                if (b[11]) begin l = AC; ao = 4; end
                if (b[10]) bs = 4;
                if (b[9] && fi) i = PC;
                if (b[8] && fo) i = PC;
                ion = b[7];
                iof = b[6];
            end
            q.push_back(mk(l, i, c, 0, 0, bs, ao));
        end else begin
            q.push_back(iv ? mk(AR, Z, Z, 1, 0, 7, 0) : 26'd0);
            case (op)
                3'd0, 3'd1, 3'd2: begin
                    q.push_back(mk(DR, Z, Z, 1, 0, 7, 0));
                    q.push_back(mk(AC, Z, Z, 0, 0, 0, int'(op) + 1));
                end
                3'd3: q.push_back(mk(Z, Z, Z, 0, 1, 4, 0));
                3'd4: q.push_back(mk(PC, Z, Z, 0, 0, 1, 0));
                3'd5: begin
                    q.push_back(mk(Z, AR, Z, 0, 1, 2, 0));
                    q.push_back(mk(PC, Z, Z, 0, 0, 1, 0));
                end
                default: begin
                    q.push_back(mk(DR, Z, Z, 1, 0, 7, 0));
                    q.push_back(mk(Z, DR, Z, 0, 0, 0, 0));
                    q.push_back(mk(Z, dz ? PC : Z, Z, 0, 1, 3, 0));
                end
            endcase
        end
        for (int k = 0; k < q.size(); k++) begin
            step(k, q[k], pick(st_idx, st_n, k), nc);
            if (k >= 3 && m_ien && (fi | fo)) m_r = 1'b1;
            if (k == 3 && ion) m_ien = 1'b1;
            else if (k == 3 && iof) m_ien = 1'b0;
        end
        if (m_r && !hlt) begin
            step(0, mk(TR, Z, AR, 0, 0, 2, 0), pick(st_idx, st_n, -1), nc);
            step(1, mk(Z, Z, PC, 0, 1, 6, 0), pick(st_idx, st_n, -1), nc);
            step(2, mk(Z, PC, Z, 0, 0, 0, 0), pick(st_idx, st_n, -1), nc);
            m_r   = 1'b0;
            m_ien = 1'b0;
        end
    endtask

    initial begin
        int          nc;
        int          bit_n;
        logic [2:0]  op;
        logic        iv;
        logic [11:0] b;
        logic [5:0]  fl;
        int          rr_bits[10] = '{11, 10, 9, 7, 6, 5, 4, 3, 2, 1};
        int          io_bits[6]  = '{11, 10, 9, 8, 7, 6};

        reset            = 1'b0;
        bus_if.ir        = '0;
        bus_if.ac_zero   = 1'b0;
        bus_if.ac_neg    = 1'b0;
        bus_if.dr_zero   = 1'b0;
        bus_if.e_flag    = 1'b0;
        bus_if.fgi       = 1'b0;
        bus_if.fgo       = 1'b0;
        bus_if.mem_ready = 1'b1;
        bus_if.run       = 1'b0;
        m_r              = 1'b0;
        m_ien            = 1'b0;
        cur_ir           = '0;
        cur_fl           = '0;

        #2;
        chk("rst_sc", 32'(bus_if.sc), 32'd0);
        chk("rst_r", 32'(bus_if.r_cycle), 32'd0);
        chk("rst_ien", 32'(bus_if.ien), 32'd0);
        chk("rst_halted", 32'(bus_if.halted), 32'd0);
        chk("rst_mem", 32'(bus_if.mem_rd | bus_if.mem_wr), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        run_instr(16'h2123, 6'b000000, 0, 0, nc);
        chk("lda_cycles", nc, 6);
        run_instr(16'h9123, 6'b000000, 1, 3, nc);
        chk("add_ind_cycles", nc, 9);
        run_instr(16'h6055, 6'b001000, 0, 0, nc);
        chk("isz_cycles", nc, 7);

        run_instr(16'hF080, 6'b000010, 0, 0, nc);
        @(posedge clk);
        #1;
        chk("ion_ien", 32'(bus_if.ien), 32'd1);
        chk("ion_no_r", 32'(bus_if.r_cycle), 32'd0);
        run_instr(16'h2010, 6'b000010, 0, 0, nc);
        chk("lda_int_cycles", nc, 9);
        @(posedge clk);
        #1;
        chk("rt_ien_off", 32'(bus_if.ien), 32'd0);
        chk("rt_r_off", 32'(bus_if.r_cycle), 32'd0);

        run_instr(16'h7001, 6'b000000, 0, 0, nc);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            #1;
            chk("hlt_halted", 32'(bus_if.halted), 32'd1);
            chk("hlt_sc", 32'(bus_if.sc), 32'd0);
            chk("hlt_sig", 32'(obs()), 32'd0);
        end
        @(negedge clk);
        bus_if.run = 1'b1;
        #1;
        chk("run_edge_halted", 32'(bus_if.halted), 32'd1);
        @(posedge clk);
        #1 bus_if.run = 1'b0;
        run_instr(16'h4321, 6'b000000, 0, 0, nc);
        chk("bun_cycles", nc, 5);

        run_instr(16'hF080, 6'b000000, 0, 0, nc);
        cur_ir = 16'h3042;
        cur_fl = 6'b000000;
        nc = 0;
        step(0, mk(AR, Z, Z, 0, 0, 2, 0), 0, nc);
        step(1, mk(IR, PC, Z, 1, 0, 7, 0), 0, nc);
        step(2, mk(AR, Z, Z, 0, 0, 5, 0), 0, nc);
        step(3, 26'd0, 0, nc);
        @(negedge clk);
        bus_if.mem_ready = 1'b0;
        #1;
        chk("sta_t4_wr", 32'(bus_if.mem_wr), 32'd1);
        chk("sta_t4_sc", 32'(bus_if.sc), 32'd4);
        chk("sta_t4_ien", 32'(bus_if.ien), 32'd1);
        reset = 1'b0;
        #1;
        chk("arst_wr", 32'(bus_if.mem_wr), 32'd0);
        chk("arst_sc", 32'(bus_if.sc), 32'd0);
        chk("arst_r", 32'(bus_if.r_cycle), 32'd0);
        chk("arst_ien", 32'(bus_if.ien), 32'd0);
        chk("arst_ld", 32'(bus_if.ld), 32'd0);
        m_r   = 1'b0;
        m_ien = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;

        for (int n = 0; n < 300; n++) begin
            op = 3'($urandom_range(0, 7));
            iv = 1'($urandom_range(0, 1));
            if (op == 3'd7) begin
                bit_n = iv ? io_bits[$urandom_range(0, 5)]
                           : rr_bits[$urandom_range(0, 9)];
                b = 12'd1 << bit_n;
            end else begin
                b = 12'($urandom);
            end
            fl = {4'($urandom_range(0, 15)),
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0};
            run_instr({iv, op, b}, fl, -1, 0, nc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/ctrl_unit_intr.md
CTRL_UNIT_INTR -- requirements
Module: ctrl_unit_intr

Interface
REQ-001 Parameter WORD_W, default 16, instruction/data word width; SHALL satisfy WORD_W >= ADDR_W+4.
REQ-002 Parameter ADDR_W, default 12, address width; SHALL be >= 12.
REQ-003 Parameter SC_W, default 3, sequence-counter width (T0..T(2^SC_W-1)); SHALL be >= 3.
REQ-004 Port clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port reset  in  1  asynchronous, active-low reset.
REQ-006 Port ir  in  WORD_W  instruction register: I=ir[WORD_W-1], opcode=ir[WORD_W-2:WORD_W-4] (decoded D0..D7), micro-op bits ir[11:0].
REQ-007 Ports ac_zero, ac_neg, dr_zero, e_flag, fgi, fgo  in  1 each  datapath/IO status flags.
REQ-008 Port mem_ready  in  1  memory completes the current mem_rd/mem_wr this cycle.
REQ-009 Port run  in  1  single-cycle pulse restarting a halted unit.
REQ-010 Ports ld, inr, clr  out  6 each  {AR,PC,DR,AC,IR,TR} load/increment/clear strobes.
REQ-011 Ports mem_rd, mem_wr  out  1 each  memory read/write request.
REQ-012 Port bus_sel  out  3  bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM.
REQ-013 Port alu_op  out  3  0 none, 1 AND, 2 ADD, 3 LDA(DR), 4 INPR, 5 CMA, 6 CIR, 7 CIL.
REQ-014 Ports sc  out  SC_W; r_cycle, ien, halted  out  1 each  current state visibility.

Function
REQ-015 Decode SHALL follow the basic-computer hardwired sequence: T0 AR<-PC; T1 IR<-M[AR], PC+1; T2 AR<-IR[ADDR_W-1:0]; T3 indirect AR<-M[AR] when D7'=1 and I=1.
REQ-016 Memory-reference execution: AND/ADD/LDA DR<-M at T4, AC op at T5; STA M<-AC T4; BUN PC<-AR T4; BSA M<-PC, AR+1 T4, PC<-AR T5; ISZ DR<-M T4, DR+1 T5, M<-DR T6 plus PC+1 when dr_zero at T6.
REQ-017 Register-reference (D7,I=0) and IO (D7,I=1) execute at T3 only: CLA, CLE, CMA, CIR, CIL, INC, SPA, SNA, SZA, SZE, HLT; INP, OUT, SKI, SKO, ION, IOF; skips assert inr PC when their flag condition holds.
REQ-018 SC SHALL clear on the final T state of every instruction and increment otherwise; wrap at 2^SC_W-1 back to 0 SHALL NOT occur in legal flow.
REQ-019 Wait states: while mem_rd or mem_wr is asserted and mem_ready=0, SC, R, IEN and halted SHALL hold and all ld/inr/clr strobes SHALL be 0; mem_rd/mem_wr/bus_sel/alu_op stay stable.
REQ-020 Interrupt flip-flop R SHALL set on a clock edge when SC is not T0/T1/T2, IEN=1 and (fgi|fgo)=1, unless stalled.
REQ-021 With R=1 the cycle SHALL be: RT0 AR clear, TR<-PC; RT1 M[AR]<-TR, PC clear; RT2 PC+1, IEN<-0, R<-0, SC<-0; r_cycle=R.
REQ-022 ION sets IEN, IOF clears IEN at T3 edge; IEN change from ION SHALL not allow R to set in that same edge.
REQ-023 HLT SHALL set halted at T3 edge; while halted SC holds 0, all strobes and memory requests are 0.
REQ-024 run=1 while halted SHALL clear halted on that edge; run while not halted is ignored.
REQ-025 Simultaneous final-state and interrupt condition: SC clears and R sets on the same edge; next cycle is RT0.

Reset
REQ-026 reset=0 SHALL asynchronously force SC=0, R=0, IEN=0, halted=0; after release the first cycle is T0 (ld AR=1, bus_sel=2).
REQ-027 reset assertion mid-instruction or mid-wait SHALL abandon the instruction; no strobe persists past reset assertion.

Verification
REQ-028 LDA direct, mem_ready=1: T0..T5 then SC=0; T4 mem_rd=1, ld DR=1; T5 alu_op=3, ld AC=1.
REQ-029 ADD indirect with mem_ready=0 for 3 cycles at T1: SC holds 1 for 4 cycles, strobes 0 until ready, total 9 cycles.
REQ-030 ION then fgi=1 during next instruction T3: R=1 after that instruction; RT0..RT2 with mem_wr=1 at RT1, IEN=0 after RT2.
REQ-031 ISZ with dr_zero=1 at T6: inr PC=1, mem_wr=1, SC=0 next cycle.
REQ-032 HLT: halted=1, SC stays 0 for 10 cycles; run pulse -> next cycle T0 with ld AR=1.
REQ-033 reset=0 asserted at T4 of STA during wait: mem_wr drops immediately, SC=0, R=0, IEN=0.
